// File: rtl/vco_pkg.sv
// vco_pkg: shared state encoding, widths and gate-length helper for the VCO frequency counter.
`default_nettype none

package vco_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int GATE_SEL_W         = 2;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_GATE_BASE_LOG2 = 10;
  // Extra log2 range covered by gate_sel: each step quadruples the gate.
  localparam int GATE_SPAN_LOG2     = 2 * ((1 << GATE_SEL_W) - 1);

  function automatic logic [31:0] gate_len_f(input logic [GATE_SEL_W-1:0] sel,
                                             input int base_log2);
    return 32'd1 << (base_log2 + 2 * int'(sel));
  endfunction

endpackage

`default_nettype wire

// File: rtl/vco_edge_sync.sv
// vco_edge_sync: multi-flop synchronizer for the asynchronous VCO square wave plus rising-edge detector.
`default_nettype none

module vco_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vco_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], vco_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/vco_freq_counter.sv
// vco_freq_counter: counts VCO rising edges over a programmable gate of clk cycles and
// latches the count as a frequency code, readable byte-wise.
`default_nettype none

module vco_freq_counter
  import vco_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int GATE_BASE_LOG2 = DEF_GATE_BASE_LOG2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  vco_in,
  input  logic                  start,
  input  logic                  cont,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  input  logic [1:0]            byte_sel,
  output logic [7:0]            byte_out,
  output logic [CNT_W-1:0]      result,
  output logic                  valid,
  output logic                  ovf,
  output logic                  busy
);

  localparam int               GATE_W  = GATE_BASE_LOG2 + GATE_SPAN_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state;
  state_t              state_nx;
  logic                edge_pulse;
  logic [CNT_W-1:0]    edge_cnt;
  logic [GATE_W-1:0]   gate_cnt;
  logic [GATE_W-1:0]   gate_load;
  logic                sat;
  logic [31:0]         result_ext;

  vco_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .vco_in     (vco_in),
    .edge_pulse (edge_pulse)
  );

  // gate_sel is only consumed here, in ARM, so later changes wait for the next window.
  assign gate_load = GATE_W'(gate_len_f(gate_sel, GATE_BASE_LOG2) - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!ena) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start || cont) state_nx = ARM;
        ARM:     state_nx = GATE;
        GATE:    if (gate_cnt == '0) state_nx = LATCH;
        LATCH:   state_nx = cont ? ARM : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      gate_cnt <= '0;
      sat      <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (ena) begin
        case (state)
          ARM: begin
            edge_cnt <= '0;
            gate_cnt <= gate_load;
            sat      <= 1'b0;
          end
          GATE: begin
            if (edge_pulse) begin
              if (edge_cnt == CNT_MAX) begin
                sat <= 1'b1;
              end else begin
                edge_cnt <= edge_cnt + 1'b1;
              end
            end
            gate_cnt <= gate_cnt - 1'b1;
          end
          LATCH: begin
            result <= edge_cnt;
            ovf    <= sat;
            valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Zero-extend so byte lanes above CNT_W read back as zero.
  assign result_ext = {{(32-CNT_W){1'b0}}, result};
  assign byte_out   = result_ext[{byte_sel, 3'b000} +: 8];
  assign busy       = (state != IDLE);

endmodule

`default_nettype wire
